// File: rtl/div_share_sched_if.sv
// Client and divider-side signal bundle for div_share_sched.
// The master side is the environment (clients plus divider); the slave side is the scheduler.
interface div_share_sched_if #(
    parameter int NUM_REQ = 3
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [16*NUM_REQ-1:0] req_word;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ-1:0]    resp_valid;
    logic [9:0]            resp_data;
    logic                  resp_err;
    logic                  div_in_valid;
    logic [3:0]            div_in_data;
    logic                  div_out_valid;
    logic                  div_out_data;
    logic                  busy;

    modport master (
        output req_valid, req_word, div_out_valid, div_out_data,
        input  req_ready, resp_valid, resp_data, resp_err,
               div_in_valid, div_in_data, busy
    );

    modport slave (
        input  req_valid, req_word, div_out_valid, div_out_data,
        output req_ready, resp_valid, resp_data, resp_err,
               div_in_valid, div_in_data, busy
    );
endinterface

// File: rtl/div_share_sched.sv
// Round-robin scheduler sharing one nibble-serial divider between NUM_REQ clients.
// Optional WAIT watchdog enabled by defining DIVSCHED_TIMEOUT_EN.
module div_share_sched #(
    parameter int NUM_REQ = 3,
    parameter int TIMEOUT = 63
) (
    input  logic               clk,
    input  logic               rst_n,
    div_share_sched_if.slave   bus
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {IDLE, GRANT, SEND, WAIT, RECV, RESP} state_t;

    state_t               state_q, state_d;
    logic [IW-1:0]        last_q, last_d;
    logic [IW-1:0]        gnt_q, gnt_d;
    logic [15:0]          word_q, word_d;
    logic [1:0]           nib_q, nib_d;
    logic [9:0]           shift_q, shift_d;
    logic [3:0]           bcnt_q, bcnt_d;
    logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
    logic [NUM_REQ-1:0]   resp_valid_q, resp_valid_d;
    logic [9:0]           resp_data_q, resp_data_d;
    logic                 resp_err_q, resp_err_d;
    logic                 div_in_valid_q, div_in_valid_d;
    logic [3:0]           div_in_data_q, div_in_data_d;
    logic                 busy_q, busy_d;
`ifdef DIVSCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0]        tmo_q, tmo_d;
`endif

    logic [IW-1:0]        win;
    logic                 any_req;
    logic [15:0]          sel_word;

    // Scan last+NUM_REQ down to last+1 so the nearest requester after last wins.
    always_comb begin
        int            idx;
        logic [IW-1:0] sel;
        win     = '0;
        any_req = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = int'(last_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            sel = IW'(idx);
            if (bus.req_valid[sel]) begin
                win     = sel;
                any_req = 1'b1;
            end
        end
    end

    always_comb begin
        sel_word = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win == IW'(i)) sel_word = bus.req_word[16*i +: 16];
        end
    end

    always_comb begin
        state_d        = state_q;
        last_d         = last_q;
        gnt_d          = gnt_q;
        word_d         = word_q;
        nib_d          = nib_q;
        shift_d        = shift_q;
        bcnt_d         = bcnt_q;
        req_ready_d    = '0;
        resp_valid_d   = '0;
        resp_data_d    = resp_data_q;
        resp_err_d     = resp_err_q;
        div_in_valid_d = 1'b0;
        div_in_data_d  = '0;
`ifdef DIVSCHED_TIMEOUT_EN
        tmo_d          = tmo_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d          = GRANT;
                    gnt_d            = win;
                    last_d           = win;
                    word_d           = sel_word;
                    req_ready_d[win] = 1'b1;
                end
            end
            GRANT: begin
                state_d        = SEND;
                nib_d          = 2'd0;
                div_in_valid_d = 1'b1;
                div_in_data_d  = word_q[15:12];
                word_d         = word_q << 4;
            end
            // word_q is a shift register, so the next nibble is always at the top.
            SEND: begin
                if (nib_q == 2'd3) begin
                    state_d = WAIT;
                    shift_d = '0;
                    bcnt_d  = '0;
`ifdef DIVSCHED_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                end else begin
                    nib_d          = nib_q + 2'd1;
                    div_in_valid_d = 1'b1;
                    div_in_data_d  = word_q[15:12];
                    word_d         = word_q << 4;
                end
            end
            WAIT: begin
                if (bus.div_out_valid) begin
                    shift_d = {shift_q[8:0], bus.div_out_data};
                    bcnt_d  = 4'd1;
                    state_d = RECV;
                end
`ifdef DIVSCHED_TIMEOUT_EN
                else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    state_d             = RESP;
                    resp_valid_d[gnt_q] = 1'b1;
                    resp_data_d         = 10'h3FF;
                    resp_err_d          = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
            end
            RECV: begin
                state_d = RESP;
                if (bus.div_out_valid) begin
                    shift_d = {shift_q[8:0], bus.div_out_data};
                    bcnt_d  = bcnt_q + 4'd1;
                    if (bcnt_q == 4'd9) begin
                        resp_valid_d[gnt_q] = 1'b1;
                        resp_data_d         = shift_d;
                        resp_err_d          = 1'b0;
                    end else begin
                        state_d = RECV;
                    end
                end else begin
                    // Short burst: keep received bits at the MSB end, zero-fill below.
                    resp_valid_d[gnt_q] = 1'b1;
                    resp_data_d         = shift_q << (4'd10 - bcnt_q);
                    resp_err_d          = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            last_q         <= IW'(NUM_REQ - 1);
            gnt_q          <= '0;
            word_q         <= '0;
            nib_q          <= '0;
            shift_q        <= '0;
            bcnt_q         <= '0;
            req_ready_q    <= '0;
            resp_valid_q   <= '0;
            resp_data_q    <= '0;
            resp_err_q     <= 1'b0;
            div_in_valid_q <= 1'b0;
            div_in_data_q  <= '0;
            busy_q         <= 1'b0;
`ifdef DIVSCHED_TIMEOUT_EN
            tmo_q          <= '0;
`endif
        end else begin
            state_q        <= state_d;
            last_q         <= last_d;
            gnt_q          <= gnt_d;
            word_q         <= word_d;
            nib_q          <= nib_d;
            shift_q        <= shift_d;
            bcnt_q         <= bcnt_d;
            req_ready_q    <= req_ready_d;
            resp_valid_q   <= resp_valid_d;
            resp_data_q    <= resp_data_d;
            resp_err_q     <= resp_err_d;
            div_in_valid_q <= div_in_valid_d;
            div_in_data_q  <= div_in_data_d;
            busy_q         <= busy_d;
`ifdef DIVSCHED_TIMEOUT_EN
            tmo_q          <= tmo_d;
`endif
        end
    end

    assign bus.req_ready    = req_ready_q;
    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_data    = resp_data_q;
    assign bus.resp_err     = resp_err_q;
    assign bus.div_in_valid = div_in_valid_q;
    assign bus.div_in_data  = div_in_data_q;
    assign bus.busy         = busy_q;
endmodule

// File: tb/tb_div_share_sched.sv
// Scoreboard bench for div_share_sched: random clients, a behavioural divider stub,
// and an arbitration/response model built from the round-robin and latency rules.
module tb_div_share_sched;
    localparam int N   = 3;
    localparam int TMO = 63;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    div_share_sched_if #(.NUM_REQ(N)) bus ();
    div_share_sched #(.NUM_REQ(N), .TIMEOUT(TMO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {int c; logic [15:0] w; int cyc;} gnt_t;
    typedef struct {int c; logic [9:0] d; logic e; int cyc;} rsp_t;

    gnt_t gq[$];
    rsp_t eq[$];
    int   n_chk = 0, n_fail = 0, cyc = 0;
    int   model_last = N - 1;
    bit   model_free = 0, free_delay = 0, pend = 0;
    int   pend_c = 0;
    logic [15:0] pend_w;
    logic [15:0] cw [N];

    int   smode = 0, nib_cnt = 0, dly = 0, nbits = 0, bidx = 0;
    logic [15:0] acc;
    logic [9:0]  sq;
    bit   ovr_en = 0, silent = 0;
    logic [9:0]  ovr_q;
    int   ovr_n, ovr_dly;

    function automatic logic [9:0] qfun(input logic [15:0] w);
        return w[9:0] ^ {w[15:10], w[15:12]};
    endfunction

    function automatic logic [9:0] ljust(input logic [9:0] q, input int n);
        logic [9:0] m;
        m = 10'h3FF << (10 - n);
        return q & m;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: bound expired (cycle %0d)", nm, cyc);
    endtask

    task automatic chk_outs_zero(input string nm);
        chk(nm, 32'({bus.req_ready, bus.resp_valid, bus.resp_data, bus.resp_err,
                     bus.div_in_valid, bus.div_in_data, bus.busy}), 32'd0);
    endtask

    // Arbitration model: a free scheduler grants the first requester after the last winner.
    initial forever begin
        @(posedge clk);
        cyc++;
        if (!rst_n) continue;
        if (model_free && bus.req_valid != '0) begin
            pend_c = -1;
            for (int k = 1; k <= N; k++) begin
                int i;
                i = (model_last + k) % N;
                if (pend_c < 0 && bus.req_valid[i]) pend_c = i;
            end
            pend       = 1;
            pend_w     = cw[pend_c];
            model_last = pend_c;
            model_free = 0;
        end
        if (free_delay) begin
            model_free = 1;
            free_delay = 0;
        end
    end

    initial forever begin
        @(negedge clk);
        if (!rst_n) continue;
        if (pend) begin
            chk("grant", 32'(bus.req_ready), 32'(1) << pend_c);
            gq.push_back('{pend_c, pend_w, cyc});
            pend = 0;
        end else if (bus.req_ready != '0) begin
            chk("unexpected_grant", 32'(bus.req_ready), 32'd0);
        end
    end

    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) continue;
            if (bus.resp_valid != '0) begin
                free_delay = 1;
                if (eq.size() == 0) begin
                    chk("unexpected_resp", 32'(bus.resp_valid), 32'd0);
                end else begin
                    e = eq.pop_front();
                    chk("resp_valid", 32'(bus.resp_valid), 32'(1) << e.c);
                    chk("resp_data", 32'(bus.resp_data), 32'(e.d));
                    chk("resp_err", 32'(bus.resp_err), 32'(e.e));
                    chk("resp_cycle", cyc, e.cyc);
                end
            end
        end
    end

    // Divider stub: collects four nibbles, then answers after dly cycles with nbits bits.
    initial begin
        gnt_t g;
        bus.div_out_valid = 1'b0;
        bus.div_out_data  = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                smode = 0; nib_cnt = 0; silent = 0;
                bus.div_out_valid = 1'b0;
                bus.div_out_data  = 1'b0;
                continue;
            end
            if (smode == 1) begin
                dly--;
                if (dly == 0) begin smode = 2; bidx = 0; end
            end
            if (smode == 2) begin
                if (bidx < nbits) begin
                    bus.div_out_valid = 1'b1;
                    bus.div_out_data  = sq[9 - bidx];
                    bidx++;
                end else begin
                    bus.div_out_valid = 1'b0;
                    bus.div_out_data  = 1'b0;
                    smode = 0;
                end
            end else if (smode == 0) begin
                if (nib_cnt > 0 && !bus.div_in_valid) begin
                    chk("nibble_gap", 32'(bus.div_in_valid), 32'd1);
                    nib_cnt = 0;
                end
                if (bus.div_in_valid) begin
                    if (nib_cnt == 0) begin
                        if (gq.size() == 0) chk("nibble_without_grant", gq.size(), 1);
                        else chk("first_nibble_cycle", cyc, gq[0].cyc + 1);
                    end
                    acc = {acc[11:0], bus.div_in_data};
                    nib_cnt++;
                    if (nib_cnt == 4 && gq.size() != 0) begin
                        nib_cnt = 0;
                        g = gq.pop_front();
                        chk("serial_word", 32'(acc), 32'(g.w));
                        if (silent) begin
`ifdef DIVSCHED_TIMEOUT_EN
                            eq.push_back('{g.c, 10'h3FF, 1'b1, cyc + TMO + 1});
                            silent = 0;
`else
                            smode = 3;
`endif
                        end else begin
                            if (ovr_en) begin
                                sq = ovr_q; nbits = ovr_n; dly = ovr_dly; ovr_en = 0;
                            end else begin
                                sq    = qfun(acc);
                                dly   = $urandom_range(1, 4);
                                nbits = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 9) : 10;
                            end
                            if (nbits == 10) eq.push_back('{g.c, sq, 1'b0, cyc + dly + 10});
                            else eq.push_back('{g.c, ljust(sq, nbits), 1'b1, cyc + dly + nbits + 1});
                            smode = 1;
                        end
                    end else if (nib_cnt == 4) begin
                        nib_cnt = 0;
                    end
                end
            end
        end
    end

    task automatic raise(input int i, input logic [15:0] w);
        cw[i] = w;
        bus.req_word[16*i +: 16] = w;
        bus.req_valid[i] = 1'b1;
    endtask

    task automatic serve_all(input int budget);
        int n;
        n = 0;
        while (bus.req_valid != '0 && n < budget) begin
            @(negedge clk);
            n++;
            for (int i = 0; i < N; i++)
                if (bus.req_valid[i] && bus.req_ready[i]) bus.req_valid[i] = 1'b0;
        end
        if (bus.req_valid != '0) begin
            fail_now("serve_timeout");
            bus.req_valid = '0;
        end
    endtask

    task automatic traffic(input int cycles, input int div);
        repeat (cycles) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (bus.req_valid[i] && bus.req_ready[i]) bus.req_valid[i] = 1'b0;
                else if (!bus.req_valid[i] && $urandom_range(0, div - 1) == 0) raise(i, 16'($urandom));
            end
        end
        serve_all(1000);
    endtask

    task automatic wait_quiet(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(eq.size() == 0 && gq.size() == 0 && !pend && !bus.busy) && n < budget);
        if (n >= budget) fail_now("quiet_timeout");
    endtask

    task automatic do_reset(input string nm);
        #2;
        rst_n = 1'b0;
        bus.req_valid = '0;
        #1;
        chk_outs_zero(nm);
        gq.delete();
        eq.delete();
        pend = 0; model_free = 0; free_delay = 0; model_last = N - 1;
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
        model_free = 1;
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        bus.req_valid = '0;
        bus.req_word  = '0;
        for (int i = 0; i < N; i++) cw[i] = '0;
        repeat (3) @(negedge clk);
        chk_outs_zero("reset_state");
        #2;
        rst_n = 1'b1;
        model_free = 1;

        ovr_en = 1; ovr_q = 10'b1010100101; ovr_n = 10; ovr_dly = 4;
        @(negedge clk); raise(1, 16'h4365); serve_all(50); wait_quiet(200);

        ovr_en = 1; ovr_q = 10'b1011011111; ovr_n = 6; ovr_dly = 2;
        @(negedge clk); raise(0, 16'hBEEF); serve_all(50); wait_quiet(200);

        @(negedge clk); raise(0, 16'h1111); raise(2, 16'h2222); serve_all(200); wait_quiet(200);

        traffic(400, 3); wait_quiet(1000);
        traffic(150, 1); wait_quiet(1000);

        ovr_en = 1; ovr_q = 10'h155; ovr_n = 10; ovr_dly = 1;
        @(negedge clk); raise(0, 16'h1234); serve_all(50);
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!(smode == 2 && bidx == 5) && n < 100);
        if (n >= 100) fail_now("reach_recv");
        do_reset("reset_in_recv");
        @(negedge clk); raise(0, 16'h0F0F); serve_all(50); wait_quiet(200);

        silent = 1;
        @(negedge clk); raise(2, 16'hA5A5); serve_all(50);
`ifdef DIVSCHED_TIMEOUT_EN
        wait_quiet(400);
`else
        repeat (200) @(negedge clk);
        chk("busy_while_silent", 32'(bus.busy), 32'd1);
        do_reset("reset_after_silent");
        @(negedge clk); raise(1, 16'h7E57); serve_all(50); wait_quiet(200);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/div_share_sched.md
Name: div_share_sched

Overview:
- Scheduler sharing one nibble-serial divider core between NUM_REQ requesters.
- Round-robin arbitration; serialises the winner's 16-bit word into the divider (4 nibbles); deserialises the 10-bit serial quotient; returns it to the winner with a one-cycle response pulse.
- Sits between client blocks and the single divider instance; the divider shares clk/rst_n.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- TIMEOUT, 63, max WAIT cycles for first div_out_valid (used only with DIVSCHED_TIMEOUT_EN).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- req_valid  in  NUM_REQ  per-client request; held high with word stable until req_ready
- req_word  in  16*NUM_REQ  client i word at [16i+15:16i]; nibble [15:12] sent first
- req_ready  out  NUM_REQ  one-hot one-cycle accept pulse
- resp_valid  out  NUM_REQ  one-hot one-cycle result pulse to the accepted client
- resp_data  out  10  quotient, valid with resp_valid
- resp_err  out  1  error flag, valid with resp_valid
- div_in_valid  out  1  to divider in_valid
- div_in_data  out  4  to divider in_data
- div_out_valid  in  1  from divider out_valid
- div_out_data  in  1  from divider out_data, MSB first
- busy  out  1  high in any state except IDLE

Behaviour:
- All outputs registered. Reset value of every output is 0. Reset also clears state to IDLE, pointer last=NUM_REQ-1 (client 0 wins first), shift and counter registers to 0.
- Reset mid-operation: immediate return to IDLE. No response for the in-flight request; the client must re-request.
- FSM states: IDLE, GRANT, SEND, WAIT, RECV, RESP.
- IDLE: when any req_valid is high, pick winner g = first set bit scanning last+1, last+2, ... (mod NUM_REQ) -> GRANT.
- GRANT (1 cycle): req_ready[g]=1; capture req_word[g] and g; last<=g -> SEND.
- SEND (4 cycles): div_in_valid=1; div_in_data = word[15:12], [11:8], [7:4], [3:0] on successive cycles -> WAIT.
- WAIT: div_in_valid=0. On first div_out_valid=1, shift in that bit -> RECV with bit count 1.
- RECV: shift in one bit per cycle with div_out_valid=1, MSB first. At 10 bits -> RESP.
  - If div_out_valid drops before 10 bits: record err=1, left-justify the bits received (remaining LSBs 0), -> RESP.
- RESP (1 cycle): resp_valid[g]=1, resp_data, resp_err -> IDLE.
- A requester seen in IDLE is never granted in the same cycle as a response.
- Minimum request-to-request spacing is therefore 1 IDLE cycle.
- Fairness: a client continuously requesting waits at most NUM_REQ-1 other transactions.
- Requests arriving while busy are held by the client (req_valid stays high). No queueing inside.
- req_valid dropped before req_ready: request silently withdrawn. Arbitration is evaluated only in IDLE.
- div_out_valid while in IDLE, GRANT or SEND: ignored.
- Latency, request seen in IDLE at cycle t: req_ready at t+1; div_in_valid t+2..t+5; resp_valid = (cycle of 10th output bit)+1.

Optional Feature:
- Macro DIVSCHED_TIMEOUT_EN.
- Defined:
  - WAIT counts cycles; reaching TIMEOUT without div_out_valid -> RESP with resp_data=10'h3FF, resp_err=1.
  - Counter clears on entering WAIT.
- Undefined:
  - No counter; WAIT waits indefinitely.
  - resp_err asserts only on a short RECV burst.

Test Plan:
- Single request, divider stub returns 10'b1010100101 after 3 WAIT cycles: client1 word 16'h4365 -> req_ready=3'b010 at t+1; div_in_data 4,3,6,5 at t+2..t+5; resp_valid=3'b010, resp_data=10'h2A5, resp_err=0.
- All three clients request continuously, 6 transactions -> grant order 0,1,2,0,1,2; each resp_valid matches its preceding req_ready.
- Client2 alone after client0 served, then client0 and client2 together -> client2 first (pointer after 0 is 1, then 2), client0 next.
- Stub drops div_out_valid after 6 bits 101101 -> resp_data=10'b1011010000, resp_err=1, back in IDLE next cycle.
- rst_n low during RECV bit 5 -> all outputs 0 asynchronously. After release, a new client0 request completes normally with resp_err=0.
- With DIVSCHED_TIMEOUT_EN, TIMEOUT=63, stub silent -> resp_data=10'h3FF, resp_err=1 after 63 WAIT cycles. Without the macro -> busy stays 1, no resp_valid within 200 cycles.
